// File: rtl/lcd_pkg.sv
// Shared LCD1602 definitions for the read and write paths: bus-phase states,
// register-select codes, busy-flag bit position and a counter-width helper.
package lcd_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StEHigh,
      StHold
   } lcd_state_e;

   localparam logic        RS_IR  = 1'b0;
   localparam logic        RS_DR  = 1'b1;
   localparam int unsigned BF_BIT = 7;

   // Bits needed to hold the largest of four counts without wrapping.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter for bus-phase timing; saturates at zero and flags it.
module lcd_timer #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_reader.sv
// LCD1602 read-cycle generator (SETUP/EHIGH/HOLD) with registered bus outputs.
// Optional busy-flag polling is built when LCD_BUSY_POLL_EN is defined.
module lcd_reader
   import lcd_pkg::*;
#(
   parameter int unsigned T_AS     = 1,
   parameter int unsigned T_PW     = 2,
   parameter int unsigned T_H      = 1,
   parameter int unsigned POLL_MAX = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       req_rs,
   input  logic [7:0] db_in,
   input  logic       poll,
   output logic       e,
   output logic       rs,
   output logic       rw,
   output logic       busy,
   output logic       rd_valid,
   output logic [7:0] rd_data,
   output logic       poll_done,
   output logic       poll_timeout
);

   localparam int unsigned CW = cnt_width(T_AS, T_PW, T_H, POLL_MAX);

   lcd_state_e    state_q;
   logic          tmr_load;
   logic [CW-1:0] tmr_val;
   logic          tmr_zero;
   logic          poll_start;
   logic          poll_again;
   logic          start;

`ifdef LCD_BUSY_POLL_EN
   logic          poll_mode_q;
   logic [CW-1:0] poll_cnt_q;

   assign poll_start = (state_q == StIdle) && poll;
   // Another read only while the busy flag is still set and reads remain.
   assign poll_again = poll_mode_q && rd_data[BF_BIT] && (poll_cnt_q < CW'(POLL_MAX));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         poll_mode_q  <= 1'b0;
         poll_cnt_q   <= '0;
         poll_done    <= 1'b0;
         poll_timeout <= 1'b0;
      end else begin
         poll_done    <= 1'b0;
         poll_timeout <= 1'b0;
         if (poll_start) begin
            poll_mode_q <= 1'b1;
            poll_cnt_q  <= '0;
         end else if (poll_mode_q && (state_q == StEHigh) && tmr_zero) begin
            poll_cnt_q <= poll_cnt_q + CW'(1);
         end else if (poll_mode_q && (state_q == StHold) && tmr_zero && !poll_again) begin
            poll_mode_q <= 1'b0;
            if (rd_data[BF_BIT]) poll_timeout <= 1'b1;
            else                 poll_done    <= 1'b1;
         end
      end
   end
`else
   logic unused_poll;

   assign unused_poll  = poll;
   assign poll_start   = 1'b0;
   assign poll_again   = 1'b0;
   assign poll_done    = 1'b0;
   assign poll_timeout = 1'b0;
`endif

   assign start = req | poll_start;

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               tmr_load = 1'b1;
               tmr_val  = CW'(T_AS - 1);
            end
         end
         StSetup: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = CW'(T_PW - 1);
            end
         end
         StEHigh: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               tmr_val  = CW'(T_H - 1);
            end
         end
         StHold: begin
            if (tmr_zero && poll_again) begin
               tmr_load = 1'b1;
               tmr_val  = CW'(T_AS - 1);
            end
         end
         default: ;
      endcase
   end

   lcd_timer #(
      .W (CW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         e        <= 1'b0;
         rs       <= RS_IR;
         rw       <= 1'b0;
         busy     <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= 8'h00;
      end else begin
         rd_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StSetup;
                  rs      <= poll_start ? RS_IR : req_rs;
                  rw      <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            StSetup: begin
               if (tmr_zero) begin
                  state_q <= StEHigh;
                  e       <= 1'b1;
               end
            end
            StEHigh: begin
               if (tmr_zero) begin
                  state_q  <= StHold;
                  e        <= 1'b0;
                  rd_data  <= db_in;
                  rd_valid <= 1'b1;
               end
            end
            StHold: begin
               if (tmr_zero) begin
                  if (poll_again) begin
                     state_q <= StSetup;
                  end else begin
                     state_q <= StIdle;
                     rw      <= 1'b0;
                     busy    <= 1'b0;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_reader.sv
// Bench for lcd_reader: cycle-window model of read transactions checked every cycle,
// plus literal checks of the documented scenarios. Poll cases follow LCD_BUSY_POLL_EN.
module tb_lcd_reader;

   localparam int unsigned T_AS     = 1;
   localparam int unsigned T_PW     = 2;
   localparam int unsigned T_H      = 1;
   localparam int unsigned POLL_MAX = 4;
   localparam int          L        = T_AS + T_PW + T_H;
`ifdef LCD_BUSY_POLL_EN
   localparam bit POLL_EN = 1'b1;
`else
   localparam bit POLL_EN = 1'b0;
`endif

   logic       clk, rst, req, req_rs, poll;
   logic [7:0] db_in;
   logic       e, rs, rw, busy, rd_valid, poll_done, poll_timeout;
   logic [7:0] rd_data;

   lcd_reader #(
      .T_AS     (T_AS),
      .T_PW     (T_PW),
      .T_H      (T_H),
      .POLL_MAX (POLL_MAX)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_rs       (req_rs),
      .db_in        (db_in),
      .poll         (poll),
      .e            (e),
      .rs           (rs),
      .rw           (rw),
      .busy         (busy),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .poll_done    (poll_done),
      .poll_timeout (poll_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_valid = 0;
   int n_done  = 0;
   int n_tmo   = 0;

   // Model: a read occupies L cycles from rd_start; outputs follow from the offset.
   int         cyc = 0;
   int         rd_start;
   int         m_reads;
   int         m_done_cyc;
   int         m_tmo_cyc;
   logic       m_rs;
   logic       m_poll;
   logic [7:0] m_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      rd_start   = -100;
      m_reads    = 0;
      m_done_cyc = -1;
      m_tmo_cyc  = -1;
      m_rs       = 1'b0;
      m_poll     = 1'b0;
      m_data     = 8'h00;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         int off;
         off = cyc - rd_start;
         if (off >= 0 && off < L) begin
            if (off == T_AS + T_PW - 1) begin
               m_data = db_in;
               m_reads++;
            end
            if (off == L - 1 && m_poll) begin
               if (!m_data[7]) begin
                  m_poll     = 1'b0;
                  m_done_cyc = cyc + 1;
               end else if (m_reads >= POLL_MAX) begin
                  m_poll    = 1'b0;
                  m_tmo_cyc = cyc + 1;
               end else begin
                  rd_start = cyc + 1;
               end
            end
         end else if (POLL_EN && poll) begin
            rd_start = cyc + 1;
            m_rs     = 1'b0;
            m_poll   = 1'b1;
            m_reads  = 0;
         end else if (req) begin
            rd_start = cyc + 1;
            m_rs     = req_rs;
         end
      end
      cyc++;
      #2;
   endtask

   always @(negedge clk) begin : cmp
      int   off;
      logic win;
      off = cyc - rd_start;
      win = (off >= 0) && (off < L);
      if (rd_valid === 1'b1)     n_valid++;
      if (poll_done === 1'b1)    n_done++;
      if (poll_timeout === 1'b1) n_tmo++;
      chk("cyc_e", e, win && off >= T_AS && off < T_AS + T_PW);
      chk("cyc_rw", rw, win);
      chk("cyc_busy", busy, win);
      chk("cyc_rs", rs, m_rs);
      chk("cyc_rd_valid", rd_valid, win && off == T_AS + T_PW);
      chk("cyc_rd_data", rd_data, m_data);
      chk("cyc_poll_done", poll_done, cyc == m_done_cyc);
      chk("cyc_poll_timeout", poll_timeout, cyc == m_tmo_cyc);
   end

   int v0, d0, t0;

   initial begin
      rst = 1'b0; req = 1'b0; req_rs = 1'b0; db_in = 8'h00; poll = 1'b0;
      model_reset();
      #1;
      chk("rst_e", e, 1'b0);
      chk("rst_rw", rw, 1'b0);
      chk("rst_rs", rs, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rd_data", rd_data, 8'h00);
      tick(); tick();
      rst = 1'b1;
      tick(); tick();

      // Single data-register read.
      req = 1'b1; req_rs = 1'b1; db_in = 8'h41;
      tick();
      req = 1'b0;
      chk("rd1_setup_e", e, 1'b0);
      chk("rd1_setup_rw", rw, 1'b1);
      chk("rd1_setup_rs", rs, 1'b1);
      tick();
      chk("rd1_e_c2", e, 1'b1);
      tick();
      chk("rd1_e_c3", e, 1'b1);
      tick();
      chk("rd1_valid_c4", rd_valid, 1'b1);
      chk("rd1_data_c4", rd_data, 8'h41);
      tick();
      chk("rd1_idle_busy", busy, 1'b0);
      chk("rd1_idle_rs_held", rs, 1'b1);
      tick();

      // Requests while busy are dropped.
      v0 = n_valid;
      req = 1'b1; req_rs = 1'b0; db_in = 8'h3C;
      repeat (5) tick();
      req = 1'b0;
      repeat (4) tick();
      chk("busy_req_one_valid", n_valid - v0, 1);
      chk("busy_req_data", rd_data, 8'h3C);

      // Asynchronous reset during EHIGH.
      v0 = n_valid;
      req = 1'b1; req_rs = 1'b1; db_in = 8'h99;
      tick();
      req = 1'b0;
      tick();
      chk("abort_e_before", e, 1'b1);
      #1 rst = 1'b0;
      model_reset();
      #1;
      chk("abort_e", e, 1'b0);
      chk("abort_rw", rw, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_data", rd_data, 8'h00);
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("abort_no_valid", n_valid - v0, 0);
      req = 1'b1; req_rs = 1'b1; db_in = 8'h5A;
      tick();
      req = 1'b0;
      repeat (5) tick();
      chk("after_abort_valid", n_valid - v0, 1);
      chk("after_abort_data", rd_data, 8'h5A);

`ifdef LCD_BUSY_POLL_EN
      // Poll: busy for three reads, then ready.
      v0 = n_valid; d0 = n_done; t0 = n_tmo;
      poll = 1'b1; db_in = 8'h80;
      tick();
      poll = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         db_in = (i <= 11) ? 8'h80 : 8'h05;
         tick();
      end
      chk("poll_ok_reads", n_valid - v0, 4);
      chk("poll_ok_done", n_done - d0, 1);
      chk("poll_ok_tmo", n_tmo - t0, 0);
      chk("poll_ok_data", rd_data, 8'h05);

      // Poll: never ready.
      v0 = n_valid; d0 = n_done; t0 = n_tmo;
      poll = 1'b1; db_in = 8'hFF;
      tick();
      poll = 1'b0;
      repeat (20) tick();
      chk("poll_to_reads", n_valid - v0, 4);
      chk("poll_to_tmo", n_tmo - t0, 1);
      chk("poll_to_done", n_done - d0, 0);

      // Poll beats req.
      v0 = n_valid; d0 = n_done;
      poll = 1'b1; req = 1'b1; req_rs = 1'b1; db_in = 8'h22;
      tick();
      poll = 1'b0; req = 1'b0;
      chk("both_rs", rs, 1'b0);
      repeat (8) tick();
      chk("both_reads", n_valid - v0, 1);
      chk("both_done", n_done - d0, 1);
      chk("both_data", rd_data, 8'h22);
`else
      // Poll input has no effect.
      poll = 1'b1;
      tick(); tick();
      chk("poll_ign_busy", busy, 1'b0);
      poll = 1'b0;
      tick();

      v0 = n_valid; d0 = n_done; t0 = n_tmo;
      poll = 1'b1; req = 1'b1; req_rs = 1'b1; db_in = 8'h22;
      tick();
      poll = 1'b0; req = 1'b0;
      chk("both_rs", rs, 1'b1);
      repeat (8) tick();
      chk("both_reads", n_valid - v0, 1);
      chk("both_done", n_done - d0, 0);
      chk("both_tmo", n_tmo - t0, 0);
      chk("both_data", rd_data, 8'h22);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
